// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program store, PC stepping and valid/ready instruction issue
module program_sequencer #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [5:0]        prog_data,
    output logic [5:0]        instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  issued_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [5:0] HALT_WORD = 6'b110000;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

    state_t            state, state_next;
    logic [5:0]        store [DEPTH];
    logic [5:0]        rd_word;
    logic [5:0]        last_issued;
    logic [ADDR_W-1:0] pc_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              issue;

    assign busy        = (state == S_FETCH) || (state == S_EXEC);
    assign halted      = (state == S_HALTED);
    assign instr_valid = (state == S_EXEC) && !rd_word[5];
    assign issue       = instr_valid && instr_ready;
    // Between issues the decoder keeps seeing the last word it accepted.
    assign instruction = instr_valid ? rd_word : last_issued;

    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            store[prog_addr] <= prog_data;
        end
        if (state == S_FETCH) begin
            rd_word <= store[pc];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            issued_count <= '0;
            last_issued  <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            issued_count <= cnt_next;
            if (issue) begin
                last_issued <= rd_word;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        cnt_next   = issued_count;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_next    = '0;
                    cnt_next   = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (!rd_word[5]) begin
                    if (instr_ready) begin
                        pc_next    = pc + ADDR_W'(1);
                        cnt_next   = (issued_count == '1) ? issued_count : issued_count + CNT_W'(1);
                        state_next = S_FETCH;
                    end
                end else if (!rd_word[4]) begin
                    pc_next    = rd_word[ADDR_W-1:0];
                    state_next = S_FETCH;
                end else if (rd_word == HALT_WORD) begin
                    pc_next    = pc + ADDR_W'(1);
                    state_next = S_HALTED;
                end else begin
                    pc_next    = pc + ADDR_W'(1);
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - self-checking bench for program_sequencer
module tb_program_sequencer;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = 4'd0;
    logic [5:0] prog_data = 6'd0;
    logic       instr_ready = 1'b0;
    logic [5:0] instruction;
    logic       instr_valid;
    logic [3:0] pc;
    logic       busy;
    logic       halted;
    logic [7:0] issued_count;

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;

    // Reference interpreter: mode, program counter and whether the current word has been fetched.
    int         m_mode = M_IDLE;
    bit         m_fetched = 1'b0;
    logic [3:0] m_pc = 4'd0;
    logic [7:0] m_cnt = 8'd0;
    logic [5:0] m_last = 6'd0;
    logic [5:0] m_mem [16] = '{default: 6'd0};
    logic [5:0] issued_q [$];
    logic [5:0] w;
    logic       exp_valid;
    logic [5:0] exp_instr;

    always #5 clk = ~clk;

    program_sequencer #(.ADDR_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .busy(busy), .halted(halted), .issued_count(issued_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [5:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int budget);
        for (int i = 0; i < budget && !halted; i++) tick();
        check(name, 32'(halted), 32'd1);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            w = m_mem[m_pc];
            exp_valid = (m_mode == M_RUN) && m_fetched && !w[5];
            exp_instr = exp_valid ? w : m_last;
            check("instr_valid", 32'(instr_valid), 32'(exp_valid));
            check("instruction", 32'(instruction), 32'(exp_instr));
            check("pc", 32'(pc), 32'(m_pc));
            check("busy", 32'(busy), 32'(m_mode == M_RUN));
            check("halted", 32'(halted), 32'(m_mode == M_HALT));
            check("issued_count", 32'(issued_count), 32'(m_cnt));
            check("ctrl_never_issued", 32'(instr_valid && instruction[5]), 32'd0);
            if (instr_valid && instr_ready) issued_q.push_back(instruction);
            if (rst) begin
                m_mode = M_IDLE;
                m_fetched = 1'b0;
                m_pc = 4'd0;
                m_cnt = 8'd0;
                m_last = 6'd0;
            end else begin
                if (m_mode != M_RUN && prog_we) m_mem[prog_addr] = prog_data;
                if (m_mode != M_RUN) begin
                    if (start) begin
                        m_mode = M_RUN;
                        m_fetched = 1'b0;
                        m_pc = 4'd0;
                        m_cnt = 8'd0;
                    end
                end else if (!m_fetched) begin
                    m_fetched = 1'b1;
                end else if (!w[5]) begin
                    if (instr_ready) begin
                        m_last = w;
                        m_pc = m_pc + 4'd1;
                        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                        m_fetched = 1'b0;
                    end
                end else if (w[5:4] == 2'b10) begin
                    m_pc = w[3:0];
                    m_fetched = 1'b0;
                end else if (w == 6'b110000) begin
                    m_pc = m_pc + 4'd1;
                    m_mode = M_HALT;
                end else begin
                    m_pc = m_pc + 4'd1;
                    m_fetched = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        // Reset with a simultaneous start that must be ignored.
        start = 1'b1;
        tick();
        checking = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        tick();
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(issued_count), 32'd0);

        // Straight-line program ending in HALT.
        load(4'd0, 6'b000101);
        load(4'd1, 6'b011010);
        load(4'd2, 6'b011111);
        load(4'd3, 6'b110000);
        issued_q.delete();
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_halted("prog_halted", 40);
        check("prog_pc", 32'(pc), 32'd4);
        check("prog_count", 32'(issued_count), 32'd3);
        check("prog_n", 32'(issued_q.size()), 32'd3);
        if (issued_q.size() == 3) begin
            check("prog_w0", 32'(issued_q[0]), 32'h05);
            check("prog_w1", 32'(issued_q[1]), 32'h1A);
            check("prog_w2", 32'(issued_q[2]), 32'h1F);
        end

        // Backpressure on the first word.
        instr_ready = 1'b0;
        issued_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_instr", 32'(instruction), 32'h05);
            check("bp_pc", 32'(pc), 32'd0);
            check("bp_valid", 32'(instr_valid), 32'd1);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("bp_single", 32'(issued_q.size()), 32'd1);
        check("bp_count", 32'(issued_count), 32'd1);
        check("bp_drop", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        wait_halted("bp_halted", 40);

        // Jump loop, with a write attempted while busy.
        load(4'd0, 6'b000001);
        load(4'd1, 6'b100000);
        issued_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prog_we = (i == 3);
            prog_addr = 4'd0;
            prog_data = 6'b000111;
            tick();
        end
        prog_we = 1'b0;
        check("jmp_n", 32'(issued_q.size()), 32'd5);
        n = 0;
        foreach (issued_q[i]) if (issued_q[i] != 6'b000001) n++;
        check("jmp_words", 32'(n), 32'd0);
        check("jmp_not_halted", 32'(halted), 32'd0);
        tick();
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);

        // Full store without HALT: pc wraps, count passes 16.
        for (int i = 0; i < 16; i++) load(4'(i), 6'b000010);
        issued_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(40);
        check("wrap_count", 32'(issued_count), 32'd20);
        check("wrap_pc", 32'(pc), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // NOP filtering and halt timing.
        load(4'd0, 6'b111111);
        load(4'd1, 6'b000011);
        load(4'd2, 6'b110000);
        issued_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            tick();
            if (halted) n = i;
        end
        check("nop_halt_cycles", 32'(n), 32'd6);
        check("nop_n", 32'(issued_q.size()), 32'd1);
        if (issued_q.size() == 1) check("nop_word", 32'(issued_q[0]), 32'h03);

        // Write while halted, then restart.
        load(4'd0, 6'b001000);
        issued_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_count", 32'(issued_count), 32'd0);
        tick(2);
        check("restart_n", 32'(issued_q.size()), 32'd1);
        if (issued_q.size() >= 1) check("restart_word", 32'(issued_q[0]), 32'h08);
        check("restart_cnt1", 32'(issued_count), 32'd1);
        wait_halted("restart_halted", 40);

        // Write and start in the same idle cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issued_q.delete();
        prog_we = 1'b1;
        prog_addr = 4'd0;
        prog_data = 6'b000100;
        start = 1'b1;
        tick();
        prog_we = 1'b0;
        start = 1'b0;
        tick(2);
        check("same_cycle_n", 32'(issued_q.size()), 32'd1);
        if (issued_q.size() >= 1) check("same_cycle_word", 32'(issued_q[0]), 32'h04);
        wait_halted("final_halted", 40);

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
